// File: rtl/ss_3to8_thermometer_decoder.sv
// 3-to-8 thermometer decoder with direct load and timed ramp/triangle sweeps.
// therm and code_out are registered together so therm always matches code_out.
module ss_3to8_thermometer_decoder #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_code,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               abort,
  output logic [7:0]         therm,
  output logic [2:0]         code_out,
  output logic               out_valid,
  output logic               busy
);

  localparam logic [1:0] ModeDirect = 2'b00;
  localparam logic [1:0] ModeUp     = 2'b01;
  localparam logic [1:0] ModeTri    = 2'b11;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e             state_q, state_d;
  logic [2:0]         code_q, code_d;
  logic [7:0]         therm_q, therm_d;
  logic               valid_q, valid_d;
  logic               tri_q, tri_d;
  logic               rise_q, rise_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Bits [k:1] set, bit 0 always clear.
  function automatic logic [7:0] decode(input logic [2:0] k);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 1; i < 8; i++) begin
      t[i] = (3'(i) <= k);
    end
    return t;
  endfunction

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    tri_d   = tri_q;
    rise_d  = rise_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          code_d  = in_code;
          valid_d = 1'b1;
          if (mode != ModeDirect) begin
            state_d = StSweep;
            tri_d   = (mode == ModeTri);
            rise_d  = (mode == ModeUp) || ((mode == ModeTri) && (in_code != 3'd7));
            dwell_d = dwell_cycles;
            cnt_d   = '0;
          end
        end
      end
      StSweep: begin
        if (abort) begin
          state_d = StIdle;
          code_d  = 3'd0;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (rise_q) begin
            // Only a ramp-up can sit at 7 while rising; triangle flips to falling on 6->7.
            if (code_q == 3'd7) begin
              state_d = StIdle;
            end else begin
              code_d  = code_q + 3'd1;
              valid_d = 1'b1;
              if (tri_q && (code_q == 3'd6)) rise_d = 1'b0;
            end
          end else begin
            if (code_q == 3'd0) begin
              state_d = StIdle;
            end else begin
              code_d  = code_q - 3'd1;
              valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    therm_d = decode(code_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= 3'd0;
      therm_q <= 8'h00;
      valid_q <= 1'b0;
      tri_q   <= 1'b0;
      rise_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      therm_q <= therm_d;
      valid_q <= valid_d;
      tri_q   <= tri_d;
      rise_q  <= rise_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StSweep);
  assign therm     = therm_q;
  assign code_out  = code_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ss_3to8_thermometer_decoder.sv
// Directed bench for ss_3to8_thermometer_decoder; expectations are hand-computed.
module tb_ss_3to8_thermometer_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [1:0] mode;
  logic [3:0] dwell_cycles;
  logic       abort;
  logic [7:0] therm;
  logic [2:0] code_out;
  logic       out_valid;
  logic       busy;

  int n_cmp;
  int n_err;

  logic [7:0]  tab [8];
  logic [63:0] seq;
  int          pulses, busy_cnt, ready_hi, bad_therm;
  logic        post_ov, post_busy, post_ready;
  logic [2:0]  post_code;
  logic [7:0]  post_therm;

  ss_3to8_thermometer_decoder #(.DWELL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .mode         (mode),
    .dwell_cycles (dwell_cycles),
    .abort        (abort),
    .therm        (therm),
    .code_out     (code_out),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one sweep request, then record each busy cycle; pulsed codes are packed as nibbles.
  task automatic run_sweep(input logic [1:0] m, input logic [2:0] c, input logic [3:0] d,
                           input logic [3:0] abort_at);
    logic armed;
    armed = (abort_at != 4'hf);
    @(negedge clk);
    in_valid = 1'b1; mode = m; in_code = c; dwell_cycles = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seq = '0; pulses = 0; busy_cnt = 0; ready_hi = 0; bad_therm = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (in_ready) ready_hi++;
      if (therm !== tab[code_out]) bad_therm++;
      if (out_valid) begin
        pulses++;
        seq = {seq[59:0], 1'b0, code_out};
      end
      if (armed && code_out == abort_at[2:0]) begin
        abort = 1'b1;
        armed = 1'b0;
      end
    end
    abort      = 1'b0;
    post_ov    = out_valid;
    post_busy  = busy;
    post_ready = in_ready;
    post_code  = code_out;
    post_therm = therm;
  endtask

  initial begin
    int ov_cnt;
    n_cmp = 0; n_err = 0;
    tab[0] = 8'h00; tab[1] = 8'h02; tab[2] = 8'h06; tab[3] = 8'h0e;
    tab[4] = 8'h1e; tab[5] = 8'h3e; tab[6] = 8'h7e; tab[7] = 8'hfe;
    rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; mode = 2'b00;
    dwell_cycles = 4'd0; abort = 1'b0;
    #12;
    check("rst_therm", 64'(therm), 64'h00);
    check("rst_code", 64'(code_out), 64'd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);

    // Abort while idle must do nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ov", 64'(out_valid), 64'd0);
    check("idle_abort_busy", 64'(busy), 64'd0);

    // Direct codes 0..7 back to back.
    in_valid = 1'b1; mode = 2'b00; in_code = 3'd0;
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i < 7) in_code = 3'(i + 1);
      else in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("direct_therm%0d", i), 64'(therm), 64'(tab[i]));
      check($sformatf("direct_code%0d", i), 64'(code_out), 64'(i));
      if (out_valid) ov_cnt++;
    end
    check("direct_ov_count", 64'(ov_cnt), 64'd8);
    @(negedge clk);
    check("direct_ov_after", 64'(out_valid), 64'd0);

    // Ramp-up 5, dwell 2.
    run_sweep(2'b01, 3'd5, 4'd2, 4'hf);
    check("ru_busy", 64'(busy_cnt), 64'd9);
    check("ru_pulses", 64'(pulses), 64'd3);
    check("ru_seq", seq, 64'h567);
    check("ru_ready", 64'(ready_hi), 64'd0);
    check("ru_therm_ok", 64'(bad_therm), 64'd0);
    check("ru_final", 64'(post_therm), 64'hfe);
    check("ru_post_ov", 64'(post_ov), 64'd0);
    check("ru_post_ready", 64'(post_ready), 64'd1);

    // Triangle 6, dwell 0.
    run_sweep(2'b11, 3'd6, 4'd0, 4'hf);
    check("tri6_busy", 64'(busy_cnt), 64'd9);
    check("tri6_seq", seq, 64'h676543210);
    check("tri6_final", 64'(post_therm), 64'h00);
    check("tri6_post_ov", 64'(post_ov), 64'd0);

    // Triangle 7 starts falling; triangle 0 rises first.
    run_sweep(2'b11, 3'd7, 4'd0, 4'hf);
    check("tri7_seq", seq, 64'h76543210);
    check("tri7_busy", 64'(busy_cnt), 64'd8);
    run_sweep(2'b11, 3'd0, 4'd0, 4'hf);
    check("tri0_seq", seq, 64'h012345676543210);
    check("tri0_busy", 64'(busy_cnt), 64'd15);

    // Ramp-down 4, dwell 3, abort when code 2 appears.
    run_sweep(2'b10, 3'd4, 4'd3, 4'd2);
    check("ab_busy", 64'(busy_cnt), 64'd9);
    check("ab_seq", seq, 64'h432);
    check("ab_code", 64'(post_code), 64'd0);
    check("ab_therm", 64'(post_therm), 64'h00);
    check("ab_ov", 64'(post_ov), 64'd1);
    check("ab_busy_after", 64'(post_busy), 64'd0);
    check("ab_ready", 64'(post_ready), 64'd1);

    // Abort coinciding with a step boundary wins.
    run_sweep(2'b01, 3'd5, 4'd0, 4'd5);
    check("abstep_seq", seq, 64'h5);
    check("abstep_code", 64'(post_code), 64'd0);
    check("abstep_ov", 64'(post_ov), 64'd1);

    // Degenerate starts.
    run_sweep(2'b01, 3'd7, 4'd1, 4'hf);
    check("ru7_busy", 64'(busy_cnt), 64'd2);
    check("ru7_pulses", 64'(pulses), 64'd1);
    check("ru7_final", 64'(post_therm), 64'hfe);
    check("ru7_post_ov", 64'(post_ov), 64'd0);
    run_sweep(2'b10, 3'd0, 4'd0, 4'hf);
    check("rd0_busy", 64'(busy_cnt), 64'd1);
    check("rd0_seq", seq, 64'h0);

    // Asynchronous reset mid-triangle.
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b11; in_code = 3'd0; dwell_cycles = 4'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_therm", 64'(therm), 64'h00);
    check("arst_code", 64'(code_out), 64'd0);
    check("arst_ov", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("arst_no_pulse", 64'(ov_cnt), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; mode = 2'b00; in_code = 3'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("arst_direct3", 64'(therm), 64'h0e);
    check("arst_direct3_ov", 64'(out_valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
